// File: rtl/moonbase_bus_responder.sv
// Target side of the 4-bit CPU nibble bus: address latch, 256x4 RAM, device writes, host loader.
// Optional code-bank write protection is enabled by defining MOONBASE_WRITE_PROTECT_EN.
module moonbase_bus_responder #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter bit          DEV_WR_REG  = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] cpu_out,
    output logic [5:0] cpu_in,
    output logic       cpu_reset,
    output logic [6:0] dev_addr,
    output logic [3:0] dev_wdata,
    output logic       dev_wr,
    input  logic [1:0] dev_rdata,
    input  logic       ld_start,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic [7:0] ld_addr,
    input  logic [3:0] ld_data,
    input  logic       ld_done,
    output logic       wp_err
);

    localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {StHold, StRun, StLoad} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
    logic [6:0]      latch_q;
    logic [3:0]      mem [256];

    logic       strobe;
    logic       bus_bank;
    logic       in_run;
    logic       cpu_ram_wr_req;
    logic       cpu_ram_wr;
    logic       dev_hit;
    logic [7:0] rd_addr;
    logic [7:0] wr_addr;
    logic [3:0] ram_rdata;

    assign strobe   = cpu_out[7];
    assign bus_bank = cpu_out[6];
    assign in_run   = (state_q == StRun);

    // While strobing, the CPU is fetching code, so reads come from bank 1.
    assign rd_addr   = {strobe | bus_bank, latch_q};
    assign wr_addr   = {bus_bank, latch_q};
    assign ram_rdata = mem[rd_addr];
    assign cpu_in    = {dev_rdata, ram_rdata};

    assign cpu_ram_wr_req = in_run & ~strobe & ~cpu_out[5];
    assign dev_hit        = in_run & ~strobe & ~cpu_out[4];

    assign cpu_reset = (state_q != StRun);
    assign ld_ready  = (state_q == StLoad);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            StHold: begin
                if (ld_start) begin
                    state_d = StLoad;
                end else if (hold_cnt_q == CntW'(1)) begin
                    state_d = StRun;
                end else begin
                    hold_cnt_d = hold_cnt_q - CntW'(1);
                end
            end
            StRun: begin
                if (ld_start) state_d = StLoad;
            end
            StLoad: begin
                if (ld_done) begin
                    state_d    = StHold;
                    hold_cnt_d = CntW'(HOLD_CYCLES);
                end
            end
            default: state_d = StHold;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StHold;
            hold_cnt_q <= CntW'(HOLD_CYCLES);
            latch_q    <= 7'd0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            if (strobe) latch_q <= cpu_out[6:0];
        end
    end

`ifdef MOONBASE_WRITE_PROTECT_EN
    logic wp_err_q;

    assign cpu_ram_wr = cpu_ram_wr_req & ~bus_bank;
    assign wp_err     = wp_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_err_q <= 1'b0;
        end else if (cpu_ram_wr_req && bus_bank) begin
            wp_err_q <= 1'b1;
        end else if (ld_start) begin
            wp_err_q <= 1'b0;
        end
    end
`else
    assign cpu_ram_wr = cpu_ram_wr_req;
    assign wp_err     = 1'b0;
`endif

    // RAM is not reset; the loader owns it outside RUN.
    always_ff @(posedge clk) begin
        if (state_q == StLoad && ld_valid) begin
            mem[ld_addr] <= ld_data;
        end else if (cpu_ram_wr) begin
            mem[wr_addr] <= cpu_out[3:0];
        end
    end

    if (DEV_WR_REG) begin : g_dev_reg
        logic       dev_wr_q;
        logic [6:0] dev_addr_q;
        logic [3:0] dev_wdata_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dev_wr_q    <= 1'b0;
                dev_addr_q  <= 7'd0;
                dev_wdata_q <= 4'd0;
            end else begin
                dev_wr_q <= dev_hit;
                if (dev_hit) begin
                    dev_addr_q  <= latch_q;
                    dev_wdata_q <= cpu_out[3:0];
                end
            end
        end

        assign dev_wr    = dev_wr_q;
        assign dev_addr  = dev_addr_q;
        assign dev_wdata = dev_wdata_q;
    end else begin : g_dev_comb
        assign dev_wr    = dev_hit;
        assign dev_addr  = latch_q;
        assign dev_wdata = cpu_out[3:0];
    end

endmodule

// File: tb/tb_moonbase_bus_responder.sv
// Randomised self-checking bench for moonbase_bus_responder against a behavioural bus model.
module tb_moonbase_bus_responder;

    localparam int unsigned HOLD = 2;
`ifdef MOONBASE_WRITE_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif
    localparam logic [7:0] IDLE = 8'h30;
    localparam int MHold = 0;
    localparam int MRun  = 1;
    localparam int MLoad = 2;

    logic       clk;
    logic       reset_n;
    logic [7:0] cpu_out;
    logic [5:0] cpu_in;
    logic       cpu_reset;
    logic [6:0] dev_addr;
    logic [3:0] dev_wdata;
    logic       dev_wr;
    logic [1:0] dev_rdata;
    logic       ld_start;
    logic       ld_valid;
    logic       ld_ready;
    logic [7:0] ld_addr;
    logic [3:0] ld_data;
    logic       ld_done;
    logic       wp_err;

    moonbase_bus_responder #(
        .HOLD_CYCLES(HOLD),
        .DEV_WR_REG (1'b1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cpu_out  (cpu_out),
        .cpu_in   (cpu_in),
        .cpu_reset(cpu_reset),
        .dev_addr (dev_addr),
        .dev_wdata(dev_wdata),
        .dev_wr   (dev_wr),
        .dev_rdata(dev_rdata),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_done  (ld_done),
        .wp_err   (wp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model of the bus target
    logic [3:0] m_mem [256];
    bit         m_known [256];
    logic [6:0] m_latch;
    int         m_mode;
    int         m_hold;
    bit         m_wp;
    bit         m_dev_wr;
    logic [6:0] m_dev_addr;
    logic [3:0] m_dev_wdata;

    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        m_latch = 7'd0; m_mode = MHold; m_hold = HOLD; m_wp = 1'b0;
        m_dev_wr = 1'b0; m_dev_addr = 7'd0; m_dev_wdata = 4'd0;
    endtask

    function automatic logic [7:0] model_rd_addr();
        return {cpu_out[7] | cpu_out[6], m_latch};
    endfunction

    // Advance the model by one clock with the currently driven inputs, then the DUT.
    task automatic tick();
        logic [7:0] a;
        bit run;
        run = (m_mode == MRun);
        m_dev_wr = run && !cpu_out[7] && !cpu_out[4];
        if (m_dev_wr) begin
            m_dev_addr  = m_latch;
            m_dev_wdata = cpu_out[3:0];
        end
        if (ld_start) m_wp = 1'b0;
        if (run && !cpu_out[7] && !cpu_out[5]) begin
            a = {cpu_out[6], m_latch};
            if (PROTECT && cpu_out[6]) begin
                m_wp = 1'b1;
            end else begin
                m_mem[a] = cpu_out[3:0];
                m_known[a] = 1'b1;
            end
        end
        if (m_mode == MLoad && ld_valid) begin
            m_mem[ld_addr] = ld_data;
            m_known[ld_addr] = 1'b1;
        end
        if (cpu_out[7]) m_latch = cpu_out[6:0];
        case (m_mode)
            MHold: begin
                if (ld_start) m_mode = MLoad;
                else if (m_hold == 1) m_mode = MRun;
                else m_hold--;
            end
            MRun: if (ld_start) m_mode = MLoad;
            default: if (ld_done) begin
                m_mode = MHold;
                m_hold = HOLD;
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic enter_run();
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        ld_done = 1'b1; tick(); ld_done = 1'b0;
        repeat (HOLD) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cpu_out = IDLE; dev_rdata = 2'b00;
        ld_start = 1'b0; ld_valid = 1'b0; ld_done = 1'b0; ld_addr = 8'h00; ld_data = 4'h0;
        model_reset();
        #12;
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
        checks++; if (dev_wr !== 1'b0) begin errors++; $display("FAIL reset_dev_wr: got %b want 0", dev_wr); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
        checks++; if (wp_err !== 1'b0) begin errors++; $display("FAIL reset_wp_err: got %b want 0", wp_err); end
        checks++; if ({dev_addr, dev_wdata} !== 11'd0) begin errors++; $display("FAIL reset_dev_bus: got %h/%h want 0/0", dev_addr, dev_wdata); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i <= int'(HOLD); i++) begin
            checks++;
            if (cpu_reset !== (i < int'(HOLD))) begin
                errors++; $display("FAIL release_cpu_reset[%0d]: got %b want %b", i, cpu_reset, i < int'(HOLD));
            end
            if (i < int'(HOLD)) tick();
        end
        checks++; if (dev_wr !== 1'b0 || ld_ready !== 1'b0) begin errors++; $display("FAIL release_idle: got dev_wr=%b ld_ready=%b want 0/0", dev_wr, ld_ready); end
    endtask

    task automatic test_load();
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b want 1", ld_ready); end
        ld_valid = 1'b1;
        ld_addr = 8'h80; ld_data = 4'h5; tick();
        ld_addr = 8'h81; ld_data = 4'hA; tick();
        for (int i = 0; i < 16; i++) begin
            ld_addr = 8'($urandom_range(0, 127)); ld_data = 4'($urandom); tick();
        end
        ld_valid = 1'b0;
        checks++; if (ld_ready !== 1'b1 || cpu_reset !== 1'b1) begin errors++; $display("FAIL load_hold_cpu: got ready=%b rst=%b want 1/1", ld_ready, cpu_reset); end
        ld_done = 1'b1; tick(); ld_done = 1'b0;
        checks++; if (ld_ready !== 1'b0 || cpu_reset !== 1'b1) begin errors++; $display("FAIL load_exit: got ready=%b rst=%b want 0/1", ld_ready, cpu_reset); end
        repeat (HOLD) tick();
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL load_run: got %b want 0", cpu_reset); end
        cpu_out = 8'h80; tick();
        cpu_out = 8'h40; #1;
        checks++; if (cpu_in[3:0] !== 4'h5) begin errors++; $display("FAIL load_read80: got %h want 5", cpu_in[3:0]); end
        tick();
        cpu_out = 8'h81; tick();
        cpu_out = 8'h70; #1;
        checks++; if (cpu_in[3:0] !== 4'hA) begin errors++; $display("FAIL load_read81: got %h want A", cpu_in[3:0]); end
        tick();
    endtask

    task automatic test_data_write();
        cpu_out = 8'h85; tick();
        cpu_out = 8'h1C; tick();
        cpu_out = IDLE; #1;
        checks++; if (cpu_in[3:0] !== 4'hC) begin errors++; $display("FAIL data_write_read: got %h want C", cpu_in[3:0]); end
        checks++; if (dev_wr !== 1'b0) begin errors++; $display("FAIL data_write_dev_wr: got %b want 0", dev_wr); end
        tick();
    endtask

    task automatic test_dev_write();
        cpu_out = 8'h92; tick();
        cpu_out = 8'h67; #1;
        checks++; if (dev_wr !== 1'b0) begin errors++; $display("FAIL dev_write_early: got %b want 0", dev_wr); end
        tick();
        cpu_out = IDLE;
        checks++; if ({dev_wr, dev_addr, dev_wdata} !== {1'b1, 7'h12, 4'h7}) begin
            errors++; $display("FAIL dev_write: got wr=%b addr=%h data=%h want 1/12/7", dev_wr, dev_addr, dev_wdata);
        end
        tick();
        checks++; if (dev_wr !== 1'b0) begin errors++; $display("FAIL dev_write_pulse: got %b want 0", dev_wr); end
    endtask

    task automatic test_random();
        logic [7:0] a;
        for (int i = 0; i < 400; i++) begin
            cpu_out   = 8'($urandom);
            dev_rdata = 2'($urandom);
            ld_start  = ($urandom_range(0, 39) == 0);
            ld_valid  = 1'($urandom);
            ld_addr   = 8'($urandom);
            ld_data   = 4'($urandom);
            ld_done   = ($urandom_range(0, 7) == 0);
            #1;
            checks++; if (cpu_in[5:4] !== dev_rdata) begin errors++; $display("FAIL rand_dev_rdata[%0d]: got %b want %b", i, cpu_in[5:4], dev_rdata); end
            a = model_rd_addr();
            if (m_known[a]) begin
                checks++; if (cpu_in[3:0] !== m_mem[a]) begin errors++; $display("FAIL rand_ram_read[%0d]: addr %h got %h want %h", i, a, cpu_in[3:0], m_mem[a]); end
            end
            tick();
            checks++;
            if ({dev_wr, dev_addr, dev_wdata} !== {m_dev_wr, m_dev_addr, m_dev_wdata}) begin
                errors++; $display("FAIL rand_dev[%0d]: got %b/%h/%h want %b/%h/%h", i, dev_wr, dev_addr, dev_wdata, m_dev_wr, m_dev_addr, m_dev_wdata);
            end
            checks++;
            if ({cpu_reset, ld_ready, wp_err} !== {m_mode != MRun, m_mode == MLoad, m_wp}) begin
                errors++; $display("FAIL rand_ctrl[%0d]: got rst/rdy/wp %b%b%b want %b%b%b", i, cpu_reset, ld_ready, wp_err, m_mode != MRun, m_mode == MLoad, m_wp);
            end
        end
        ld_start = 1'b0; ld_valid = 1'b0; ld_done = 1'b0; cpu_out = IDLE;
    endtask

    task automatic test_protect();
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        ld_valid = 1'b1; ld_addr = 8'h80; ld_data = 4'h9; tick(); ld_valid = 1'b0;
        ld_done = 1'b1; tick(); ld_done = 1'b0;
        repeat (HOLD) tick();
        cpu_out = 8'h80; tick();
        cpu_out = 8'h43; tick();
        cpu_out = 8'h70; #1;
        checks++; if (cpu_in[3:0] !== (PROTECT ? 4'h9 : 4'h3)) begin errors++; $display("FAIL protect_mem: got %h want %h", cpu_in[3:0], PROTECT ? 4'h9 : 4'h3); end
        repeat (3) tick();
        checks++; if (wp_err !== PROTECT) begin errors++; $display("FAIL protect_wp_err: got %b want %b", wp_err, PROTECT); end
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        checks++; if (wp_err !== 1'b0) begin errors++; $display("FAIL protect_clear: got %b want 0", wp_err); end
        ld_done = 1'b1; tick(); ld_done = 1'b0;
        repeat (HOLD) tick();
    endtask

    task automatic test_reset_mid_load();
        logic [3:0] d;
        d = 4'($urandom);
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        ld_valid = 1'b1; ld_addr = 8'h3A; ld_data = d; tick(); ld_valid = 1'b0;
        reset_n = 1'b0; model_reset(); #2;
        checks++; if (cpu_reset !== 1'b1 || ld_ready !== 1'b0) begin errors++; $display("FAIL midload_reset: got rst=%b rdy=%b want 1/0", cpu_reset, ld_ready); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (HOLD) tick();
        cpu_out = 8'hBA; tick();
        cpu_out = IDLE; #1;
        checks++; if (cpu_in[3:0] !== d || cpu_reset !== 1'b0) begin errors++; $display("FAIL midload_retain: got %h rst=%b want %h/0", cpu_in[3:0], cpu_reset, d); end
        tick();
    endtask

    initial begin
        test_reset();
        test_load();
        test_data_write();
        test_dev_write();
        test_random();
        enter_run();
        test_protect();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
